// File: rtl/register_file.sv
// Eight-entry register file with two write ports, write-through bypass on both read ports,
// and a push/pop stack pointer with a sticky under/overflow flag.
module register_file #(
  parameter int unsigned   W       = 16,
  parameter int unsigned   N       = 8,
  parameter int unsigned   AW      = 3,
  parameter logic [W-1:0]  SP_INIT = 'h0FFF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rs_addr,
  input  logic [AW-1:0] rt_addr,
  output logic [W-1:0]  rs_data,
  output logic [W-1:0]  rt_data,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [W-1:0]  wb_data,
  input  logic          wb2_en,
  input  logic [AW-1:0] wb2_addr,
  input  logic [W-1:0]  wb2_data,
  input  logic [1:0]    sp_op,
  output logic [W-1:0]  sp_addr,
  output logic [W-1:0]  sp,
  output logic          stack_err
);

  localparam logic [1:0] OpPush = 2'b01;
  localparam logic [1:0] OpPop  = 2'b10;

  logic [W-1:0] regs_q [N];
  logic [W-1:0] sp_q, sp_d;
  logic         err_q, err_d;

  // Port B is written last so it wins on an address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      if (wb_en) regs_q[wb_addr] <= wb_data;
      if (wb2_en) regs_q[wb2_addr] <= wb2_data;
    end
  end

  always_comb begin
    rs_data = regs_q[rs_addr];
    if (wb_en && (wb_addr == rs_addr)) rs_data = wb_data;
    if (wb2_en && (wb2_addr == rs_addr)) rs_data = wb2_data;
  end

  always_comb begin
    rt_data = regs_q[rt_addr];
    if (wb_en && (wb_addr == rt_addr)) rt_data = wb_data;
    if (wb2_en && (wb2_addr == rt_addr)) rt_data = wb2_data;
  end

  // Push addresses the current slot; pop addresses the slot above it.
  always_comb begin
    sp_d    = sp_q;
    err_d   = err_q;
    sp_addr = sp_q;
    unique case (sp_op)
      OpPush: begin
        sp_d = sp_q - W'(1);
        if (sp_q == '0) err_d = 1'b1;
      end
      OpPop: begin
        sp_addr = sp_q + W'(1);
        sp_d    = sp_q + W'(1);
        if (sp_q == SP_INIT) err_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q  <= SP_INIT;
      err_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  assign sp        = sp_q;
  assign stack_err = err_q;

endmodule

// File: tb/tb_register_file.sv
// Directed and randomized checks of register_file against an array/integer reference model.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  rs_addr, rt_addr, wb_addr, wb2_addr;
  logic [15:0] rs_data, rt_data, wb_data, wb2_data, sp_addr, sp;
  logic        wb_en, wb2_en, stack_err;
  logic [1:0]  sp_op;

  int total = 0;
  int bad   = 0;

  // Reference model: plain array, stack pointer as an integer taken modulo 2**16.
  logic [15:0] m_regs [8];
  int          m_sp;
  logic        m_err;

  register_file dut (
    .clk       (clk),
    .rst       (rst),
    .rs_addr   (rs_addr),
    .rt_addr   (rt_addr),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .wb2_en    (wb2_en),
    .wb2_addr  (wb2_addr),
    .wb2_data  (wb2_data),
    .sp_op     (sp_op),
    .sp_addr   (sp_addr),
    .sp        (sp),
    .stack_err (stack_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_sp  = 'h0FFF;
    m_err = 1'b0;
  endtask

  function automatic logic [15:0] exp_read(input logic [2:0] a);
    if (wb2_en && wb2_addr == a) return wb2_data;
    if (wb_en && wb_addr == a) return wb_data;
    return m_regs[a];
  endfunction

  function automatic logic [15:0] exp_sp_addr();
    if (sp_op == 2'b10) return 16'((m_sp + 1) % 65536);
    return 16'(m_sp);
  endfunction

  // Checks combinational outputs, takes one edge, advances the model, checks state.
  task automatic tick(input string tag);
    #1;
    check({tag, "/rs"}, rs_data, exp_read(rs_addr));
    check({tag, "/rt"}, rt_data, exp_read(rt_addr));
    check({tag, "/sp_addr"}, sp_addr, exp_sp_addr());
    @(posedge clk);
    #1;
    if (wb_en) m_regs[wb_addr] = wb_data;
    if (wb2_en) m_regs[wb2_addr] = wb2_data;
    if (sp_op == 2'b01) begin
      if (m_sp == 0) m_err = 1'b1;
      m_sp = (m_sp + 65535) % 65536;
    end else if (sp_op == 2'b10) begin
      if (m_sp == 'h0FFF) m_err = 1'b1;
      m_sp = (m_sp + 1) % 65536;
    end
    check({tag, "/sp"}, sp, 16'(m_sp));
    check({tag, "/err"}, {15'd0, stack_err}, {15'd0, m_err});
  endtask

  task automatic idle();
    wb_en = 0; wb2_en = 0; sp_op = 2'b00;
  endtask

  task automatic hard_reset();
    #2 rst = 1'b1;
    m_reset();
    #1;
    check("rst/sp", sp, 16'h0FFF);
    check("rst/err", {15'd0, stack_err}, 16'd0);
    #2 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    rs_addr = 0; rt_addr = 0; wb_addr = 0; wb2_addr = 0;
    wb_data = 0; wb2_data = 0;
    idle();
    m_reset();
    #3;
    check("reset/rs", rs_data, 16'h0000);
    check("reset/rt", rt_data, 16'h0000);
    check("reset/sp", sp, 16'h0FFF);
    check("reset/sp_addr", sp_addr, 16'h0FFF);
    check("reset/err", {15'd0, stack_err}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Bypass then committed value on port A.
    wb_en = 1; wb_addr = 5; wb_data = 16'h1234; rs_addr = 5;
    #1 check("bypass/a", rs_data, 16'h1234);
    tick("wr5");
    idle();
    #1 check("after/a", rs_data, 16'h1234);

    // Collision: port B wins in bypass and in the array.
    wb_en = 1; wb2_en = 1; wb_addr = 2; wb2_addr = 2;
    wb_data = 16'h1111; wb2_data = 16'h2222; rs_addr = 2; rt_addr = 2;
    #1 check("coll/bypass", rs_data, 16'h2222);
    tick("coll");
    idle();
    #1 check("coll/commit", rt_data, 16'h2222);

    wb_en = 1; wb2_en = 1; wb_addr = 1; wb2_addr = 6;
    wb_data = 16'hAAAA; wb2_data = 16'h6666;
    tick("dual");
    idle(); rs_addr = 1; rt_addr = 6;
    #1;
    check("dual/r1", rs_data, 16'hAAAA);
    check("dual/r6", rt_data, 16'h6666);

    // Push, push, pop, pop from the empty position.
    sp_op = 2'b01;
    #1 check("push1/addr", sp_addr, 16'h0FFF);
    tick("push1"); check("push1/sp", sp, 16'h0FFE);
    #1 check("push2/addr", sp_addr, 16'h0FFE);
    tick("push2"); check("push2/sp", sp, 16'h0FFD);
    sp_op = 2'b10;
    #1 check("pop1/addr", sp_addr, 16'h0FFE);
    tick("pop1");
    #1 check("pop2/addr", sp_addr, 16'h0FFF);
    tick("pop2");
    check("pops/sp", sp, 16'h0FFF);
    check("pops/err", {15'd0, stack_err}, 16'd0);

    // Underflow pop from the empty position; flag is sticky.
    #1 check("upop/addr", sp_addr, 16'h1000);
    tick("upop");
    check("upop/sp", sp, 16'h1000);
    check("upop/err", {15'd0, stack_err}, 16'd1);
    sp_op = 2'b01;
    tick("push_sticky");
    tick("push_sticky2");
    check("sticky/err", {15'd0, stack_err}, 16'd1);

    // Async reset between edges, then held across an edge with writes pending.
    idle();
    wb_en = 1; wb_addr = 3; wb_data = 16'hABCD;
    tick("wr3");
    idle(); rs_addr = 3;
    #1 check("r3/pre", rs_data, 16'hABCD);
    #2 rst = 1'b1;
    m_reset();
    #1;
    check("async/r3", rs_data, 16'h0000);
    check("async/sp", sp, 16'h0FFF);
    check("async/err", {15'd0, stack_err}, 16'd0);
    wb_en = 1; wb_addr = 4; wb_data = 16'h4444; sp_op = 2'b10;
    @(posedge clk);
    #1;
    idle(); rs_addr = 4;
    #1;
    check("rsthold/r4", rs_data, 16'h0000);
    check("rsthold/sp", sp, 16'h0FFF);
    check("rsthold/err", {15'd0, stack_err}, 16'd0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Drain to zero, then overflow push alongside a register write.
    sp_op = 2'b01;
    for (int i = 0; i < 'h0FFF; i++) tick("drain");
    check("drain/sp", sp, 16'h0000);
    wb_en = 1; wb_addr = 7; wb_data = 16'h7777; rs_addr = 7;
    #1 check("ovf/addr", sp_addr, 16'h0000);
    tick("ovf");
    check("ovf/sp", sp, 16'hFFFF);
    check("ovf/err", {15'd0, stack_err}, 16'd1);
    idle();
    #1 check("ovf/r7", rs_data, 16'h7777);

    // Randomized traffic against the model.
    hard_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < 400; i++) begin
      rs_addr  = 3'($urandom_range(0, 7));
      rt_addr  = 3'($urandom_range(0, 7));
      wb_en    = 1'($urandom_range(0, 1));
      wb2_en   = 1'($urandom_range(0, 1));
      wb_addr  = 3'($urandom_range(0, 7));
      wb2_addr = 3'($urandom_range(0, 7));
      wb_data  = 16'($urandom);
      wb2_data = 16'($urandom);
      sp_op    = 2'($urandom_range(0, 3));
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 8-entry general-purpose register file with an integrated stack pointer.
- Sits between write-back and decode: decode reads two source operands combinationally, and write-back commits up to two results per cycle (the second port serves SWAP-style dual-destination instructions).
- The stack pointer is updated by push/pop commands from the memory stage and supplies the stack memory address.
- Decode latches all outputs into its pipeline buffer.

Parameters:
- W, 16, data width of each register and of the stack pointer
- N, 8, number of general-purpose registers
- AW, 3, register address width (N = 2**AW)
- SP_INIT, 16'h0FFF, stack pointer value after reset (empty-stack position)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous active-high reset
- rs_addr  input  AW  source operand 1 address
- rt_addr  input  AW  source operand 2 address
- rs_data  output  W  source operand 1 value
- rt_data  output  W  source operand 2 value
- wb_en  input  1  write port A enable
- wb_addr  input  AW  write port A address
- wb_data  input  W  write port A data
- wb2_en  input  1  write port B enable
- wb2_addr  input  AW  write port B address
- wb2_data  input  W  write port B data
- sp_op  input  2  00 hold, 01 push, 10 pop, 11 hold
- sp_addr  output  W  memory address for the current stack access
- sp  output  W  current stack pointer value
- stack_err  output  1  sticky stack underflow/overflow flag

Behaviour:
- Reset is asynchronous: rst high immediately forces all N registers to 0, sp to SP_INIT and stack_err to 0, independent of clk. This holds mid-operation; no write or sp_op takes effect on any edge where rst is high.
- Reads are combinational from rs_addr/rt_addr, with zero-cycle latency.
- Write-through bypass: if wb_en and wb_addr == rs_addr, rs_data = wb_data. The same applies to port B. When both ports match, port B's data is returned. Same rules for rt_data.
- Writes commit on the rising clk edge. Port A writes when wb_en is high; port B writes when wb2_en is high.
- Both ports may write different addresses in the same cycle. If both target the same address, port B wins.
- No register is hardwired; R0 is writable.
- sp_op = push:
  - sp_addr = sp (combinational).
  - On the edge, sp <= sp - 1 modulo 2**W.
  - If sp == 0 before the push, stack_err <= 1 and sp still wraps to all-ones.
- sp_op = pop:
  - sp_addr = sp + 1 (combinational, modulo 2**W).
  - On the edge, sp <= sp + 1.
  - If sp == SP_INIT before the pop (empty stack), stack_err <= 1 and sp still increments.
- sp_op = hold (00 or 11): sp_addr = sp and sp is unchanged.
- stack_err stays at 1 until rst; only rst clears it.
- The register writes and sp_op are independent and may occur in the same cycle.
- Register contents and sp are never X after reset. Outputs after reset: rs_data = rt_data = 0, sp = sp_addr = SP_INIT, stack_err = 0.

Test Plan:
- Assert rst asynchronously between edges after writing R3 = 16'hABCD. Required: R3 reads 0, sp = 16'h0FFF and stack_err = 0 immediately, before the next edge.
- Set wb_en = 1, wb_addr = 5, wb_data = 16'h1234, rs_addr = 5 in the same cycle. Required: rs_data = 16'h1234 combinationally. After the edge, with wb_en = 0, rs_data is still 16'h1234.
- Dual write with wb_addr = wb2_addr = 2, wb_data = 16'h1111, wb2_data = 16'h2222. Required: bypass shows 16'h2222 and R2 = 16'h2222 after the edge. Dual write to addresses 1 and 6: both are updated.
- From reset, push twice, then pop twice. Required sequence:
  - sp_addr 0FFF, then 0FFE.
  - sp becomes 0FFE, then 0FFD.
  - pops give sp_addr 0FFE, then 0FFF, and sp returns to 0FFF.
  - stack_err stays 0.
- Pop at reset (sp = 0FFF). Required: sp_addr = 1000, sp = 1000 after the edge, stack_err = 1. stack_err stays 1 across later pushes and clears only on rst.
- Drive sp down to 0, then push. Required: sp_addr = 0, sp wraps to FFFF and stack_err = 1. A concurrent register write in the same cycle still commits.
